// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: staggered channel release after power-up,
// software re-reset via req/ack, and a divided tick once the sequence is done.
module rst_seq_gen #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 8,
   parameter int RST_DELAY    = 30,
   parameter int RST_STEP     = 2,
   parameter int RST_DURATION = 2,
   parameter int DIV          = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sw_rst_req,
   output logic              sw_rst_ack,
   output logic [NUM_CH-1:0] rst_n_out,
   output logic              seq_done,
   output logic              tick
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CMAX  = (CNT_W >= 1 && CNT_W <= 30) ? (1 << CNT_W) - 1 : 0;

   if (NUM_CH < 1) begin : g_bad_ch
      $error("rst_seq_gen: NUM_CH must be >= 1");
   end
   if (CNT_W < 1 || CNT_W > 30) begin : g_bad_w
      $error("rst_seq_gen: CNT_W out of range");
   end
   if (RST_DELAY < 1 || RST_DELAY > CMAX) begin : g_bad_dly
      $error("rst_seq_gen: RST_DELAY invalid for CNT_W");
   end
   if (RST_STEP < 1 || RST_STEP > CMAX) begin : g_bad_stp
      $error("rst_seq_gen: RST_STEP invalid for CNT_W");
   end
   if (RST_DURATION < 1 || RST_DURATION > CMAX) begin : g_bad_dur
      $error("rst_seq_gen: RST_DURATION invalid for CNT_W");
   end
   if (DIV < 1 || DIV > CMAX) begin : g_bad_div
      $error("rst_seq_gen: DIV invalid for CNT_W");
   end

   // Terminal counts: counters start at 0 on the edge after the reference edge.
   localparam logic [CNT_W-1:0] DLY_T = CNT_W'(RST_DELAY - 1);
   localparam logic [CNT_W-1:0] STP_T = CNT_W'(RST_STEP - 1);
   localparam logic [CNT_W-1:0] DUR_T = CNT_W'(RST_DURATION - 1);
   localparam logic [CNT_W-1:0] DIV_T = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CH - 1);
   localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

   typedef enum logic [1:0] {
      HOLD,
      STAGE,
      RUN,
      SWRST
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   tcnt_q, tcnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               rel;
   logic [IDX_W-1:0]   rel_ch;
   logic               accept;
   logic [NUM_CH-1:0]  rst_d;
   logic               done_d;
   logic               tick_d;
   logic               ack_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         idx_q      <= '0;
         rst_n_out  <= '0;
         seq_done   <= 1'b0;
         tick       <= 1'b0;
         sw_rst_ack <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tcnt_q     <= tcnt_d;
         idx_q      <= idx_d;
         rst_n_out  <= rst_d;
         seq_done   <= done_d;
         tick       <= tick_d;
         sw_rst_ack <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = '0;
      idx_d   = idx_q;
      rel     = 1'b0;
      rel_ch  = '0;
      accept  = 1'b0;
      unique case (state_q)
         HOLD, SWRST: begin
            if (cnt_q == ((state_q == HOLD) ? DLY_T : DUR_T)) begin
               rel     = 1'b1;
               cnt_d   = '0;
               idx_d   = ONE;
               state_d = (NUM_CH == 1) ? RUN : STAGE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STAGE: begin
            if (cnt_q == STP_T) begin
               rel    = 1'b1;
               rel_ch = idx_q;
               cnt_d  = '0;
               if (idx_q == LAST) begin
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (sw_rst_req) begin
               accept  = 1'b1;
               cnt_d   = '0;
               state_d = SWRST;
            end else if (tcnt_q != DIV_T) begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: state_d = HOLD;
      endcase
   end

   always_comb begin
      rst_d  = rst_n_out;
      done_d = seq_done;
      tick_d = 1'b0;
      ack_d  = 1'b0;
      if (rel) begin
         rst_d[rel_ch] = 1'b1;
      end
      if (rel && state_d == RUN) begin
         done_d = 1'b1;
      end
      if (state_q == RUN && !accept && tcnt_q == DIV_T) begin
         tick_d = 1'b1;
      end
      if (accept) begin
         rst_d  = '0;
         done_d = 1'b0;
         ack_d  = 1'b1;
      end
   end

endmodule
